// File: rtl/uart_xcvr_param.sv
// ============================================================================
// Module  : uart_xcvr_param
// Purpose : Parametrised full-duplex UART (DATA_BITS / STOP_BITS / CLKS_PER_BIT)
//           with synchronised RX, false-start rejection and framing-error pulse.
//           Optional parity bit enabled by defining UART_XCVR_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_xcvr_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_XCVR_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_frame_err
`ifdef UART_XCVR_PARITY_EN
  , output logic               rx_parity_err
`endif
);

  localparam int CW = $clog2(STOP_BITS*CLKS_PER_BIT+1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] C_STOP_LAST = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(DATA_BITS-1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // ---------------- TX engine ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
`ifdef UART_XCVR_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
`ifdef UART_XCVR_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
`ifdef UART_XCVR_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
`ifdef UART_XCVR_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx         = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_sh_d    = tx_data;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
`ifdef UART_XCVR_PARITY_EN
          tx_par_d   = (^tx_data) ^ PARITY_ODD;
`endif
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        // The shift register presents the current bit at its LSB.
        tx = tx_sh_q[0];
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_idx_q == C_IDX_LAST) begin
`ifdef UART_XCVR_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
`ifdef UART_XCVR_PARITY_EN
      TX_PARITY: begin
        tx = tx_par_q;
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_q == C_STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_busy = (tx_state_q != TX_IDLE);

  // ---------------- RX engine ----------------
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef UART_XCVR_PARITY_EN
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      rx_ferr_q    <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
      rx_par_bad_q <= 1'b0;
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      rx_ferr_q    <= rx_ferr_d;
`ifdef UART_XCVR_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
      rx_perr_q    <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    rx_ready_d   = 1'b0;
    rx_ferr_d    = 1'b0;
`ifdef UART_XCVR_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    rx_perr_d    = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start check: a line back high here was a glitch, not a frame.
        if (rx_cnt_q == C_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_idx_q == C_IDX_LAST) begin
`ifdef UART_XCVR_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + IW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
`ifdef UART_XCVR_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = rx_s_q ^ (^rx_sh_q) ^ PARITY_ODD;
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d  = '0;
          rx_data_d = rx_sh_q;
          if (rx_s_q) begin
`ifdef UART_XCVR_PARITY_EN
            if (rx_par_bad_q) rx_perr_d = 1'b1;
            else
`endif
            rx_ready_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // Hold off through a break so a long low line cannot re-trigger.
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_ready     = rx_ready_q;
  assign rx_frame_err = rx_ferr_q;
`ifdef UART_XCVR_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_xcvr_param.sv
// ============================================================================
// Module  : tb_uart_xcvr_param
// Purpose : Self-checking bench for uart_xcvr_param (8N1 and 7N2 instances).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_xcvr_param;

  localparam int CPB = 16;
`ifdef UART_XCVR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME0 = (1 + 8 + PAR + 1) * CPB;
  localparam int FRAME1 = (1 + 7 + PAR + 2) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data0 = '0;
  logic       tx_start0 = 1'b0;
  logic       busy0, tx0, rx0, rdy0, ferr0;
  logic [7:0] rxd0;
  logic [6:0] tx_data1 = '0;
  logic       tx_start1 = 1'b0;
  logic       busy1, tx1, rdy1, ferr1;
  logic [6:0] rxd1;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
`ifdef UART_XCVR_PARITY_EN
  logic       perr0, perr1;
  logic [7:0] perr_q0 [$];
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rdy_q0 [$];
  logic [7:0] ferr_q0 [$];
  logic [6:0] rdy_q1 [$];
  int         ferr_cnt1 = 0;
  int         both_cnt = 0;

  always #5 clk = ~clk;

  assign rx0 = loop_en ? tx0 : rx_drv;

  uart_xcvr_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)
`ifdef UART_XCVR_PARITY_EN
    , .PARITY_ODD(1'b1)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_start(tx_start0),
    .tx_busy(busy0), .tx(tx0), .rx(rx0), .rx_data(rxd0),
    .rx_ready(rdy0), .rx_frame_err(ferr0)
`ifdef UART_XCVR_PARITY_EN
    , .rx_parity_err(perr0)
`endif
  );

  uart_xcvr_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_start(tx_start1),
    .tx_busy(busy1), .tx(tx1), .rx(tx1), .rx_data(rxd1),
    .rx_ready(rdy1), .rx_frame_err(ferr1)
`ifdef UART_XCVR_PARITY_EN
    , .rx_parity_err(perr1)
`endif
  );

  always @(negedge clk) begin
    if (rdy0) rdy_q0.push_back(rxd0);
    if (ferr0) ferr_q0.push_back(rxd0);
    if (rdy0 && ferr0) both_cnt++;
    if (rdy1) rdy_q1.push_back(rxd1);
    if (ferr1) ferr_cnt1++;
`ifdef UART_XCVR_PARITY_EN
    if (perr0) perr_q0.push_back(rxd0);
`endif
  end

  // Ideal line level n cycles into a frame (n=0 is the first start cycle).
  function automatic logic exp_tx0(input logic [7:0] d, input int n);
    int b;
    b = n / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR != 0 && b == 9) return ~^d;
    return 1'b1;
  endfunction

  function automatic logic exp_tx1(input logic [6:0] d, input int n);
    int b;
    b = n / CPB;
    if (b == 0) return 1'b0;
    if (b <= 7) return d[b-1];
    if (PAR != 0 && b == 8) return ^d;
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Request a frame on dut0, then trace the line until tx_busy drops.
  task automatic send0(input logic [7:0] d, input int poke_at, input logic [7:0] poke_d,
                       output int gap, output int len, output int bad);
    gap = 0; len = 0; bad = 0;
    tx_data0 = d;
    tx_start0 = 1'b1;
    while (busy0 !== 1'b1 && gap < 4 * FRAME0) begin tick(1); gap++; end
    tx_start0 = 1'b0;
    if (busy0 !== 1'b1) begin len = -1; return; end
    do begin
      if (tx0 !== exp_tx0(d, len)) bad++;
      if (len == poke_at) begin tx_data0 = poke_d; tx_start0 = 1'b1; end
      else tx_start0 = 1'b0;
      tick(1);
      len++;
    end while (busy0 === 1'b1 && len <= 4 * FRAME0);
    tx_start0 = 1'b0;
  endtask

  // Drive one frame onto dut0's rx from the bench.
  task automatic drive_rx(input logic [7:0] d, input logic par_flip, input logic stop_v);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; tick(CPB); end
    if (PAR != 0) begin rx_drv = (~^d) ^ par_flip; tick(CPB); end
    rx_drv = stop_v;
    tick(CPB);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: tx0=%b busy0=%b tx1=%b busy1=%b, required 1 0 1 0", tx0, busy0, tx1, busy1);
    end
    checks++;
    if (rxd0 !== 8'h00 || rdy0 !== 1'b0 || ferr0 !== 1'b0 || rxd1 !== 7'h00 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx: rxd0=%h rdy0=%b ferr0=%b rxd1=%h rdy1=%b, required zeros", rxd0, rdy0, ferr0, rxd1, rdy1);
    end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_hello();
    logic [7:0] msg [5];
    logic [7:0] word;
    int gap, len, bad;
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    loop_en = 1'b1;
    rdy_q0.delete();
    ferr_q0.delete();
    for (int i = 0; i < 5; i++) begin
      send0(msg[i], -1, 8'h00, gap, len, bad);
      checks++;
      if (len !== FRAME0 || bad !== 0 || gap !== 1) begin
        errors++;
        $display("FAIL hello_tx[%0d]: len=%0d gap=%0d badbits=%0d, required len=%0d gap=1 badbits=0", i, len, gap, bad, FRAME0);
      end
    end
    tick(40);
    checks++;
    if (rdy_q0.size() !== 5 || ferr_q0.size() !== 0) begin
      errors++;
      $display("FAIL hello_count: ready=%0d ferr=%0d, required 5 0", rdy_q0.size(), ferr_q0.size());
    end
    for (int i = 0; i < 5 && i < rdy_q0.size(); i++) begin
      word = rdy_q0[i];
      checks++;
      if (word !== msg[i]) begin
        errors++;
        $display("FAIL hello_rx[%0d]: got %h, required %h", i, word, msg[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int gap, len, bad;
    logic [7:0] d;
    d = 8'hA5;
    rdy_q0.delete();
    send0(d, 20, 8'h3C, gap, len, bad);
    checks++;
    if (len !== FRAME0 || bad !== 0) begin
      errors++;
      $display("FAIL ignore_tx: len=%0d badbits=%0d, required len=%0d badbits=0", len, bad, FRAME0);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy0 !== 1'b0) bad++;
      tick(1);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignore_queued: busy seen for %0d cycles after frame, required 0", bad);
    end
    checks++;
    if (rdy_q0.size() !== 1 || (rdy_q0.size() > 0 && rdy_q0[0] !== d)) begin
      errors++;
      $display("FAIL ignore_rx: ready=%0d first=%h, required 1 frame of %h", rdy_q0.size(),
               rdy_q0.size() > 0 ? rdy_q0[0] : 8'hxx, d);
    end
  endtask

  task automatic test_false_start();
    loop_en = 1'b0;
    rx_drv = 1'b1;
    tick(10);
    rdy_q0.delete();
    ferr_q0.delete();
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(100);
    checks++;
    if (rdy_q0.size() !== 0 || ferr_q0.size() !== 0) begin
      errors++;
      $display("FAIL false_start: ready=%0d ferr=%0d, required 0 0", rdy_q0.size(), ferr_q0.size());
    end
    drive_rx(8'h5A, 1'b0, 1'b1);
    tick(30);
    checks++;
    if (rdy_q0.size() !== 1 || (rdy_q0.size() > 0 && rdy_q0[0] !== 8'h5A)) begin
      errors++;
      $display("FAIL after_false_start: ready=%0d rx_data=%h, required 1 frame of 5a", rdy_q0.size(), rxd0);
    end
  endtask

  task automatic test_frame_err();
    rdy_q0.delete();
    ferr_q0.delete();
    drive_rx(8'h81, 1'b0, 1'b0);
    rx_drv = 1'b0;
    tick(100);
    checks++;
    if (ferr_q0.size() !== 1 || rdy_q0.size() !== 0 || rxd0 !== 8'h81) begin
      errors++;
      $display("FAIL frame_err: ferr=%0d ready=%0d rx_data=%h, required 1 0 81", ferr_q0.size(), rdy_q0.size(), rxd0);
    end
    rx_drv = 1'b1;
    tick(20);
    drive_rx(8'h7E, 1'b0, 1'b1);
    tick(30);
    checks++;
    if (rdy_q0.size() !== 1 || rxd0 !== 8'h7E || ferr_q0.size() !== 1) begin
      errors++;
      $display("FAIL after_frame_err: ready=%0d ferr=%0d rx_data=%h, required 1 1 7e", rdy_q0.size(), ferr_q0.size(), rxd0);
    end
  endtask

  task automatic test_7n2();
    int len, bad, stop_hi, wait_n;
    logic [6:0] d;
    d = 7'h55;
    rdy_q1.delete();
    len = 0; bad = 0; stop_hi = 0; wait_n = 0;
    tx_data1 = d;
    tx_start1 = 1'b1;
    while (busy1 !== 1'b1 && wait_n < 4 * FRAME1) begin tick(1); wait_n++; end
    tx_start1 = 1'b0;
    while (busy1 === 1'b1 && len <= 4 * FRAME1) begin
      if (tx1 !== exp_tx1(d, len)) bad++;
      if (len >= (8 + PAR) * CPB && tx1 === 1'b1) stop_hi++;
      tick(1);
      len++;
    end
    checks++;
    if (len !== FRAME1 || bad !== 0 || stop_hi !== 2 * CPB) begin
      errors++;
      $display("FAIL 7n2_tx: len=%0d badbits=%0d stop_high=%0d, required %0d 0 %0d", len, bad, stop_hi, FRAME1, 2 * CPB);
    end
    tick(30);
    checks++;
    if (rdy_q1.size() !== 1 || rxd1 !== d || ferr_cnt1 !== 0) begin
      errors++;
      $display("FAIL 7n2_rx: ready=%0d rx_data=%h ferr=%0d, required 1 55 0", rdy_q1.size(), rxd1, ferr_cnt1);
    end
  endtask

  task automatic test_reset_mid();
    int gap, len, bad, wait_n;
    logic [7:0] d;
    loop_en = 1'b1;
    tick(5);
    wait_n = 0;
    tx_data0 = 8'hF0;
    tx_start0 = 1'b1;
    tx_data1 = 7'h2B;
    tx_start1 = 1'b1;
    while (busy0 !== 1'b1 && wait_n < 100) begin tick(1); wait_n++; end
    tx_start0 = 1'b0;
    tx_start1 = 1'b0;
    tick(5 * CPB);
    rdy_q0.delete();
    ferr_q0.delete();
    rdy_q1.delete();
    reset = 1'b1;
    tick(1);
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b0 || ferr0 !== 1'b0 || rxd0 !== 8'h00 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tx0=%b busy0=%b rdy0=%b ferr0=%b rxd0=%h busy1=%b, required 1 0 0 0 00 0",
               tx0, busy0, rdy0, ferr0, rxd0, busy1);
    end
    reset = 1'b0;
    tick(300);
    checks++;
    if (rdy_q0.size() !== 0 || ferr_q0.size() !== 0 || rdy_q1.size() !== 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: ready0=%0d ferr0=%0d ready1=%0d busy0=%b, required 0 0 0 0",
               rdy_q0.size(), ferr_q0.size(), rdy_q1.size(), busy0);
    end
    d = 8'hC3;
    send0(d, -1, 8'h00, gap, len, bad);
    tick(40);
    checks++;
    if (len !== FRAME0 || bad !== 0 || rdy_q0.size() !== 1 || rxd0 !== d) begin
      errors++;
      $display("FAIL after_reset: len=%0d badbits=%0d ready=%0d rx_data=%h, required %0d 0 1 c3",
               len, bad, rdy_q0.size(), rxd0, FRAME0);
    end
  endtask

  task automatic test_random();
    int gap, len, bad;
    logic [7:0] sent [$];
    logic [7:0] d;
    loop_en = 1'b1;
    rdy_q0.delete();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      sent.push_back(d);
      send0(d, -1, 8'h00, gap, len, bad);
      checks++;
      if (len !== FRAME0 || bad !== 0) begin
        errors++;
        $display("FAIL random_tx[%0d]: data=%h len=%0d badbits=%0d, required len=%0d badbits=0", i, d, len, bad, FRAME0);
      end
    end
    tick(40);
    checks++;
    if (rdy_q0.size() !== sent.size()) begin
      errors++;
      $display("FAIL random_count: ready=%0d, required %0d", rdy_q0.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < rdy_q0.size(); i++) begin
      checks++;
      if (rdy_q0[i] !== sent[i]) begin
        errors++;
        $display("FAIL random_rx[%0d]: got %h, required %h", i, rdy_q0[i], sent[i]);
      end
    end
  endtask

`ifdef UART_XCVR_PARITY_EN
  task automatic test_parity();
    loop_en = 1'b0;
    rx_drv = 1'b1;
    tick(10);
    rdy_q0.delete();
    ferr_q0.delete();
    perr_q0.delete();
    drive_rx(8'h5A, 1'b1, 1'b1);
    tick(30);
    checks++;
    if (perr_q0.size() !== 1 || rdy_q0.size() !== 0 || ferr_q0.size() !== 0 || rxd0 !== 8'h5A) begin
      errors++;
      $display("FAIL parity_err: perr=%0d ready=%0d ferr=%0d rx_data=%h, required 1 0 0 5a",
               perr_q0.size(), rdy_q0.size(), ferr_q0.size(), rxd0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hello();
    test_ignore_busy();
    test_false_start();
    test_frame_err();
    test_7n2();
    test_reset_mid();
    test_random();
`ifdef UART_XCVR_PARITY_EN
    test_parity();
`endif
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL ready_and_ferr: coincident pulses=%0d, required 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
